// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices
// and the timed-hold FSM encoding.
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/pipe_ctrl_hold_timer.sv
// Timed-hold FSM: latches a stage and a cycle count on accept, then keeps the
// stage held for exactly that many cycles unless aborted by a flush.
module hold_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int SW     = 3,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              abort,
  input  logic [SW-1:0]     stage_in,
  input  logic [HOLD_W-1:0] cycles_in,
  output hold_state_e       state,
  output logic [SW-1:0]     held_stage
);

  hold_state_e       next_state;
  logic [HOLD_W-1:0] count;
  logic [SW-1:0]     stage_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Count holds the cycles still to be held, including the current one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      stage_q <= '0;
    end else if (state == ST_IDLE && accept) begin
      count   <= cycles_in;
      stage_q <= stage_in;
    end else if (state == ST_HOLD) begin
      count <= count - HOLD_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_HOLD;
      ST_HOLD: if (abort || count == HOLD_W'(1)) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    held_stage = (state == ST_HOLD) ? stage_q : '0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller: turns per-stage stall requests, a
// timed hold and (possibly deferred) flush requests into per-stage strobes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 6,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSTAGE-1:0]         stallreq,
  input  logic                      hold_req,
  input  logic [$clog2(NSTAGE)-1:0] hold_stage,
  input  logic [HOLD_W-1:0]         hold_cycles,
  input  logic                      flush_req,
  input  logic [$clog2(NSTAGE)-1:0] flush_stage,
  output logic [NSTAGE-1:0]         stall,
  output logic [NSTAGE-1:0]         bubble,
  output logic [NSTAGE-1:0]         flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      busy
);

  localparam int SW = $clog2(NSTAGE);

  hold_state_e hold_state;
  logic        hold_active;
  logic [SW-1:0] held_stage;
  logic        hold_accept;
  logic        hold_abort;

  logic          lvl_valid;
  logic [SW-1:0] lvl;
  logic          pend_valid;
  logic [SW-1:0] pend_stage;
  logic          fl_valid;
  logic [SW-1:0] fl_stage;
  logic          fl_blocked;
  logic          fl_issue;

  assign hold_active = (hold_state == ST_HOLD);

  // Deepest stage that must stall this cycle.
  always_comb begin
    lvl_valid = 1'b0;
    lvl       = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stallreq[i] || (hold_active && held_stage == SW'(i))) begin
        lvl_valid = 1'b1;
        lvl       = SW'(i);
      end
    end
  end

  // A new request merges with a deferred one; the deeper stage wins.
  always_comb begin
    fl_valid = pend_valid | flush_req;
    fl_stage = pend_valid ? pend_stage : '0;
    if (flush_req && flush_stage > fl_stage) fl_stage = flush_stage;
    fl_blocked = lvl_valid && (lvl > fl_stage);
    fl_issue   = rst && fl_valid && !fl_blocked;
  end

  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      stall[k] = rst && lvl_valid && (SW'(k) <= lvl) &&
                 !(fl_issue && SW'(k) <= fl_stage);
      flush[k] = fl_issue && (k != STG_PC) && (SW'(k) <= fl_stage);
    end
    for (int k = 0; k < NSTAGE - 1; k++) begin
      bubble[k] = stall[k] & ~stall[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_stage <= '0;
    end else if (fl_issue) begin
      pend_valid <= 1'b0;
    end else if (fl_valid) begin
      pend_valid <= 1'b1;
      pend_stage <= fl_stage;
    end
  end

  // A same-cycle flush at or below the requested hold stage wins over the hold.
  assign hold_accept = hold_req && (hold_cycles != '0) && !hold_active &&
                       !(fl_issue && fl_stage >= hold_stage);
  assign hold_abort  = fl_issue && (fl_stage >= held_stage);

  hold_timer #(
    .SW     (SW),
    .HOLD_W (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .accept     (hold_accept),
    .abort      (hold_abort),
    .stage_in   (hold_stage),
    .cycles_in  (hold_cycles),
    .state      (hold_state),
    .held_stage (held_stage)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall[0] && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign busy = hold_active | pend_valid;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, checked
// against a cycle-level model built from remaining-hold and pending-flush state.
module tb_pipe_ctrl;

  localparam int N  = 6;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  stallreq;
  logic          hold_req;
  logic [SW-1:0] hold_stage;
  logic [3:0]    hold_cycles;
  logic          flush_req;
  logic [SW-1:0] flush_stage;

  logic [N-1:0]  stall, bubble, flush;
  logic [31:0]   stall_cnt;
  logic          busy;
  logic [N-1:0]  stall4, bubble4, flush4;
  logic [3:0]    stall_cnt4;
  logic          busy4;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .hold_req(hold_req),
    .hold_stage(hold_stage), .hold_cycles(hold_cycles), .flush_req(flush_req),
    .flush_stage(flush_stage), .stall(stall), .bubble(bubble), .flush(flush),
    .stall_cnt(stall_cnt), .busy(busy)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .hold_req(hold_req),
    .hold_stage(hold_stage), .hold_cycles(hold_cycles), .flush_req(flush_req),
    .flush_stage(flush_stage), .stall(stall4), .bubble(bubble4), .flush(flush4),
    .stall_cnt(stall_cnt4), .busy(busy4)
  );

  // Reference model state
  int     hold_left;
  int     hold_stg;
  bit     pend;
  int     pend_stg;
  longint cnt;

  logic [N-1:0] e_stall, e_bubble, e_flush;
  logic         e_busy;
  bit           e_issue;
  int           e_fs;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval();
    int lvl;
    lvl = -1;
    for (int i = 0; i < N; i++) if (stallreq[i]) lvl = i;
    if (hold_left > 0 && hold_stg > lvl) lvl = hold_stg;
    e_fs = 0;
    if (pend) e_fs = pend_stg;
    if (flush_req && int'(flush_stage) > e_fs) e_fs = int'(flush_stage);
    e_issue = (rst === 1'b1) && (pend || flush_req) && (lvl <= e_fs);
    for (int k = 0; k < N; k++) begin
      e_stall[k] = (rst === 1'b1) && (k <= lvl) && !(e_issue && k <= e_fs);
      e_flush[k] = e_issue && k >= 1 && k <= e_fs;
    end
    for (int k = 0; k < N; k++)
      e_bubble[k] = (k < N - 1) ? (e_stall[k] && !e_stall[k+1]) : 1'b0;
    e_busy = (hold_left > 0) || pend;
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] sr, input logic hr,
                       input int hs, input int hc, input logic fr, input int fs);
    @(negedge clk);
    rst         = r;
    stallreq    = sr;
    hold_req    = hr;
    hold_stage  = SW'(hs);
    hold_cycles = 4'(hc);
    flush_req   = fr;
    flush_stage = SW'(fs);
    #1;
    model_eval();
    chk("stall", stall, e_stall);
    chk("bubble", bubble, e_bubble);
    chk("flush", flush, e_flush);
    chk("busy", busy, e_busy);
    chk("stall_cnt", stall_cnt, 32'(cnt));
    chk("stall4", stall4, e_stall);
    chk("flush4", flush4, e_flush);
    chk("bubble4", bubble4, e_bubble);
    chk("busy4", busy4, e_busy);
    chk("stall_cnt4", stall_cnt4, (cnt > 15) ? 64'd15 : 64'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst !== 1'b1) begin
      hold_left = 0;
      pend      = 0;
      cnt       = 0;
    end else begin
      if (e_stall[0]) cnt++;
      if (e_issue) pend = 0;
      else if (pend || flush_req) begin
        pend     = 1;
        pend_stg = e_fs;
      end
      if (hold_left > 0) begin
        if (e_issue && e_fs >= hold_stg) hold_left = 0;
        else hold_left--;
      end else if (hold_req && hold_cycles != 0 &&
                   !(e_issue && e_fs >= int'(hold_stage))) begin
        hold_left = int'(hold_cycles);
        hold_stg  = int'(hold_stage);
      end
    end
  endtask

  task automatic idle();
    drive(1'b1, '0, 1'b0, 0, 0, 1'b0, 1);
  endtask

  initial begin
    rst = 1'b0; stallreq = '0; hold_req = 1'b0; hold_stage = '0;
    hold_cycles = '0; flush_req = 1'b0; flush_stage = SW'(1);
    hold_left = 0; hold_stg = 0; pend = 0; pend_stg = 0; cnt = 0;
    repeat (2) @(posedge clk);

    // Reset forces outputs low and ignores requests
    drive(1'b0, '1, 1'b1, 3, 4, 1'b1, 2);
    chk("rst_stall", stall, 6'b0);
    chk("rst_flush", flush, 6'b0);
    tick();
    idle();
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_busy", busy, 1'b0);
    tick();

    // Level stall from stage 2
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b000100, 1'b0, 0, 0, 1'b0, 1);
      chk("lvl_stall", stall, 6'b000111);
      chk("lvl_bubble", bubble, 6'b000100);
      chk("lvl_cnt", stall_cnt, 32'(i));
      tick();
    end

    // Timed hold on stage 3 for 4 cycles
    drive(1'b1, '0, 1'b1, 3, 4, 1'b0, 1);
    chk("hold_accept_stall", stall, 6'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("hold_stall", stall, 6'b001111);
      chk("hold_busy", busy, 1'b1);
      chk("hold_bubble3", bubble[3], 1'b1);
      tick();
    end
    idle();
    chk("hold_end_stall", stall, 6'b0);
    chk("hold_end_busy", busy, 1'b0);
    tick();

    // Flush blocked by deeper stall, then issued when it drops
    drive(1'b1, 6'b010000, 1'b0, 0, 0, 1'b1, 2);
    chk("blk_flush", flush, 6'b0);
    tick();
    drive(1'b1, 6'b010000, 1'b0, 0, 0, 1'b0, 1);
    chk("blk_busy", busy, 1'b1);
    chk("blk_flush2", flush, 6'b0);
    tick();
    idle();
    chk("pend_issue", flush, 6'b000110);
    tick();
    idle();
    chk("pend_busy", busy, 1'b0);
    tick();

    // Flush at stage 3 aborts a stage-2 hold
    drive(1'b1, '0, 1'b1, 2, 5, 1'b0, 1);
    tick();
    idle();
    chk("ab_hold_stall", stall, 6'b000111);
    tick();
    drive(1'b1, '0, 1'b0, 0, 0, 1'b1, 3);
    chk("ab_flush", flush, 6'b001110);
    chk("ab_stall", stall, 6'b0);
    tick();
    idle();
    chk("ab_busy", busy, 1'b0);
    chk("ab_stall_after", stall, 6'b0);
    tick();

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'b000001, 1'b0, 0, 0, 1'b0, 1);
      tick();
    end
    idle();
    chk("sat_cnt4", stall_cnt4, 4'hF);
    tick();

    // Reset during hold with a pending flush discards both
    drive(1'b1, '0, 1'b1, 4, 8, 1'b0, 1);
    tick();
    drive(1'b1, 6'b100000, 1'b0, 0, 0, 1'b1, 2);
    chk("rh_flush", flush, 6'b0);
    tick();
    drive(1'b0, '1, 1'b1, 1, 3, 1'b1, 5);
    chk("rh_stall", stall, 6'b0);
    chk("rh_bubble", bubble, 6'b0);
    chk("rh_flush_rst", flush, 6'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rh_post_stall", stall, 6'b0);
      chk("rh_post_flush", flush, 6'b0);
      chk("rh_post_busy", busy, 1'b0);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] sr;
      sr = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      drive(($urandom_range(0, 99) != 0), sr,
            ($urandom_range(0, 5) == 0), $urandom_range(0, 5), $urandom_range(0, 15),
            ($urandom_range(0, 5) == 0), $urandom_range(1, 5));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
